// File: rtl/spi_slave_driver.sv
// -----------------------------------------------------------------------------
// spi_slave_driver
//
// SPI slave endpoint on the system clock. SCLK, CS and MOSI are oversampled
// through 2-flop synchronizers, with a third flop on SCLK and CS for edge
// detection. Supports all four CPOL/CPHL modes, MSB first, active-low CS.
// Received words are presented to the user as a one-cycle valid pulse.
// Transmit words come in through a one-entry valid/ready holding buffer.
// If that buffer is empty when a word load occurs, zeros are sent (underrun).
//
// State table:
//   ST_IDLE   | CS deasserted; SCLK ignored, MISO output disabled
//   ST_ACTIVE | CS asserted; shifting RX/TX words, MISO output enabled
//
// Ports:
//   i_clk              system clock
//   i_rst              asynchronous active-high reset
//   i_spi_clk          SCLK from the master (asynchronous)
//   i_spi_cs           chip select, active low (asynchronous)
//   i_spi_mosi         MOSI (asynchronous)
//   o_spi_miso         MISO data (MSB of the TX shift register, registered)
//   o_spi_miso_oe      MISO output enable for the top-level tristate
//   i_user_write_data  next word to transmit
//   i_user_write_valid write request
//   o_user_write_ready holding buffer is empty
//   o_user_read_data   last received word
//   o_user_read_valid  one-cycle pulse, o_user_read_data is new
// -----------------------------------------------------------------------------
module spi_slave_driver #(
    parameter int P_DATA_WIDTH = 8,
    parameter bit P_CPOL       = 1'b0,
    parameter bit P_CPHL       = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_spi_clk,
    input  logic                    i_spi_cs,
    input  logic                    i_spi_mosi,
    output logic                    o_spi_miso,
    output logic                    o_spi_miso_oe,
    input  logic [P_DATA_WIDTH-1:0] i_user_write_data,
    input  logic                    i_user_write_valid,
    output logic                    o_user_write_ready,
    output logic [P_DATA_WIDTH-1:0] o_user_read_data,
    output logic                    o_user_read_valid
);

    localparam int CW = (P_DATA_WIDTH > 2) ? $clog2(P_DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(P_DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchronizer chains: [0] first flop, [1] synchronized, [2] previous.
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [P_DATA_WIDTH-1:0] rx_q, rx_d;
    logic [P_DATA_WIDTH-1:0] tx_q, tx_d;
    logic [P_DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                    wr_ready_q, wr_ready_d;
    logic [P_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    miso_q, miso_d;
    logic                    oe_q, oe_d;

    logic sclk_rise, sclk_fall;
    logic lead_edge, trail_edge;
    logic sample_edge, shift_edge;
    logic cs_fall, cs_rise;
    logic mosi_s;
    logic wr_accept;
    logic load;

    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
    assign lead_edge   = P_CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = P_CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = P_CPHL ? trail_edge : lead_edge;
    assign shift_edge  = P_CPHL ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_q[1] & cs_q[2];
    assign cs_rise     = cs_q[1] & ~cs_q[2];
    assign mosi_s      = mosi_q[1];

    // Writes are only taken while the buffer is empty, so an accept can never
    // collide with a load that consumes the buffer in the same cycle.
    assign wr_accept   = i_user_write_valid & wr_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        buf_data_d = buf_data_q;
        wr_ready_d = wr_ready_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        load       = 1'b0;
        // Pin-facing outputs lag the internal state by one register stage.
        miso_d     = tx_q[P_DATA_WIDTH-1];
        oe_d       = (state_q == ST_ACTIVE);

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    rx_d    = '0;
                    // With sample-first timing the first bit must be on MISO
                    // before the first SCLK edge.
                    load    = ~P_CPHL;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    // Abort: any partial word is dropped, buffer is kept.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = '0;
                end else begin
                    if (sample_edge) begin
                        rx_d = {rx_q[P_DATA_WIDTH-2:0], mosi_s};
                        if (cnt_q == CNT_LAST) begin
                            cnt_d      = '0;
                            rd_data_d  = {rx_q[P_DATA_WIDTH-2:0], mosi_s};
                            rd_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // Counter at zero on a shift edge marks a word boundary:
                    // the end of the previous word (CPHL=0) or the first
                    // edge of the next word (CPHL=1).
                    if (shift_edge) begin
                        if (cnt_q == '0) begin
                            load = 1'b1;
                        end else begin
                            tx_d = {tx_q[P_DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            tx_d       = wr_ready_q ? '0 : buf_data_q;
            wr_ready_d = 1'b1;
        end

        if (wr_accept) begin
            buf_data_d = i_user_write_data;
            wr_ready_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_q     <= {3{P_CPOL}};
            cs_q       <= 3'b111;
            mosi_q     <= 2'b00;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            buf_data_q <= '0;
            wr_ready_q <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            sclk_q     <= {sclk_q[1:0], i_spi_clk};
            cs_q       <= {cs_q[1:0], i_spi_cs};
            mosi_q     <= {mosi_q[0], i_spi_mosi};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            buf_data_q <= buf_data_d;
            wr_ready_q <= wr_ready_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
        end
    end

    assign o_spi_miso         = miso_q;
    assign o_spi_miso_oe      = oe_q;
    assign o_user_write_ready = wr_ready_q;
    assign o_user_read_data   = rd_data_q;
    assign o_user_read_valid  = rd_valid_q;

endmodule

// File: tb/tb_spi_slave_driver.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_driver
//
// Four instances, one per CPOL/CPHL mode, share one normalized SCLK (rising =
// leading edge for every instance), MOSI and the user write bus; only the
// selected instance sees CS low and the write valid. Expected read words and
// expected MISO words are queued at stimulus time and popped by independent
// monitors.
// -----------------------------------------------------------------------------
module tb_spi_slave_driver;

    localparam int H = 8;  // SCLK half period in i_clk cycles

    logic       clk;
    logic       rst;
    logic       sclk_raw;
    logic       cs_pin;
    logic       mosi;
    logic [7:0] wr_data;
    logic       wr_valid;
    int         sel;
    logic       chk_miso;

    logic [3:0] miso;
    logic [3:0] oe;
    logic [3:0] wr_ready;
    logic [3:0] rd_valid;
    logic [7:0] rd_data [4];

    int n_cmp;
    int n_mis;

    logic [7:0] exp_rx [$];
    logic [7:0] exp_tx [$];

    event sample_ev;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam bit CPOL = (g >= 2);
        localparam bit CPHL = ((g % 2) == 1);
        logic sclk_g;
        logic cs_g;
        logic wv_g;
        assign sclk_g = sclk_raw ^ CPOL;
        assign cs_g   = (sel == g) ? cs_pin : 1'b1;
        assign wv_g   = (sel == g) ? wr_valid : 1'b0;
        spi_slave_driver #(
            .P_DATA_WIDTH(8),
            .P_CPOL      (CPOL),
            .P_CPHL      (CPHL)
        ) u_dut (
            .i_clk             (clk),
            .i_rst             (rst),
            .i_spi_clk         (sclk_g),
            .i_spi_cs          (cs_g),
            .i_spi_mosi        (mosi),
            .o_spi_miso        (miso[g]),
            .o_spi_miso_oe     (oe[g]),
            .i_user_write_data (wr_data),
            .i_user_write_valid(wv_g),
            .o_user_write_ready(wr_ready[g]),
            .o_user_read_data  (rd_data[g]),
            .o_user_read_valid (rd_valid[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        wait_cyc(1);
        cs_pin = 1'b0;
        wait_cyc(H);
    endtask

    task automatic cs_high();
        wait_cyc(H);
        cs_pin = 1'b1;
        wait_cyc(2 * H);
    endtask

    task automatic user_write(input logic [7:0] d);
        int t;
        t = 0;
        while (!wr_ready[sel] && t < 400) begin
            wait_cyc(1);
            t++;
        end
        if (!wr_ready[sel]) begin
            fail_now("write_ready_timeout");
        end else begin
            wr_data  = d;
            wr_valid = 1'b1;
            wait_cyc(1);
            wr_valid = 1'b0;
        end
    endtask

    // Master side of one word (or a partial word when nbits < 8).
    task automatic spi_word(input logic [7:0] w, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            if ((sel % 2) == 0) begin
                mosi = w[7-b];
                wait_cyc(H);
                if (nbits == 8 && chk_miso) -> sample_ev;
                sclk_raw = 1'b1;
                wait_cyc(H);
                sclk_raw = 1'b0;
            end else begin
                sclk_raw = 1'b1;
                mosi     = w[7-b];
                wait_cyc(H);
                if (nbits == 8 && chk_miso) -> sample_ev;
                sclk_raw = 1'b0;
                wait_cyc(H);
            end
        end
    endtask

    // Read monitor
    initial begin
        logic [3:0] prev;
        prev = 4'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rd_valid[i]) begin
                    chk("read_valid_pulse_width", {31'b0, prev[i]}, 32'd0);
                    if (i != sel || exp_rx.size() == 0) begin
                        fail_now($sformatf("read_unexpected inst=%0d data=%0h", i, rd_data[i]));
                    end else begin
                        chk($sformatf("read_data mode%0d", i), {24'b0, rd_data[i]}, {24'b0, exp_rx.pop_front()});
                    end
                end
            end
            prev = rd_valid;
        end
    end

    // MISO monitor
    initial begin
        logic [7:0] bits;
        int nb;
        bits = 8'h00;
        nb   = 0;
        forever begin
            @(sample_ev);
            bits = {bits[6:0], miso[sel]};
            nb++;
            if (nb == 8) begin
                nb = 0;
                if (exp_tx.size() == 0) begin
                    fail_now($sformatf("miso_unexpected word=%0h", bits));
                end else begin
                    chk($sformatf("miso_word mode%0d", sel), {24'b0, bits}, {24'b0, exp_tx.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mode_rx [2];
        logic [7:0] mode_tx [2];
        n_cmp    = 0;
        n_mis    = 0;
        rst      = 1'b1;
        sclk_raw = 1'b0;
        cs_pin   = 1'b1;
        mosi     = 1'b0;
        wr_data  = 8'h00;
        wr_valid = 1'b0;
        sel      = 0;
        chk_miso = 1'b1;
        mode_rx[0] = 8'h81; mode_rx[1] = 8'h7E;
        mode_tx[0] = 8'h55; mode_tx[1] = 8'hAA;

        // Reset state
        wait_cyc(4);
        chk("rst_miso", {31'b0, miso[0]}, 32'd0);
        chk("rst_oe", {31'b0, oe[0]}, 32'd0);
        chk("rst_ready", {31'b0, wr_ready[0]}, 32'd1);
        chk("rst_read_data", {24'b0, rd_data[0]}, 32'd0);
        chk("rst_read_valid", {31'b0, rd_valid[0]}, 32'd0);
        rst = 1'b0;
        wait_cyc(4);
        chk("post_rst_ready_mode3", {31'b0, wr_ready[3]}, 32'd1);

        // Mode 0 single word
        sel = 0;
        user_write(8'hA5);
        chk("m0_ready_after_write", {31'b0, wr_ready[0]}, 32'd0);
        exp_rx.push_back(8'h3C);
        exp_tx.push_back(8'hA5);
        cs_low();
        chk("m0_oe_active", {31'b0, oe[0]}, 32'd1);
        chk("m0_ready_after_load", {31'b0, wr_ready[0]}, 32'd1);
        spi_word(8'h3C, 8);
        cs_high();
        chk("m0_oe_idle", {31'b0, oe[0]}, 32'd0);

        // All four modes, two words per CS
        for (int m = 0; m < 4; m++) begin
            sel = m;
            user_write(mode_tx[0]);
            exp_rx.push_back(mode_rx[0]);
            exp_rx.push_back(mode_rx[1]);
            exp_tx.push_back(mode_tx[0]);
            exp_tx.push_back(mode_tx[1]);
            cs_low();
            chk($sformatf("mode%0d_oe", m), {31'b0, oe[m]}, 32'd1);
            fork
                user_write(mode_tx[1]);
                begin
                    spi_word(mode_rx[0], 8);
                    spi_word(mode_rx[1], 8);
                end
            join
            cs_high();
            chk($sformatf("mode%0d_ready_end", m), {31'b0, wr_ready[m]}, 32'd1);
        end

        // Underrun
        sel = 0;
        exp_rx.push_back(8'hFF);
        exp_tx.push_back(8'h00);
        cs_low();
        spi_word(8'hFF, 8);
        chk("underrun_ready", {31'b0, wr_ready[0]}, 32'd1);
        cs_high();

        // Abort after 5 bits
        cs_low();
        spi_word(8'hF0, 5);
        cs_high();
        chk("abort_read_data_held", {24'b0, rd_data[0]}, 32'h0000_00FF);
        exp_rx.push_back(8'h12);
        exp_tx.push_back(8'h00);
        cs_low();
        spi_word(8'h12, 8);
        cs_high();

        // Reset mid-transfer
        user_write(8'hF0);
        cs_low();
        user_write(8'h77);
        chk("rstmid_ready_full", {31'b0, wr_ready[0]}, 32'd0);
        spi_word(8'hAB, 3);
        wait_cyc(6);
        chk("rstmid_miso_before", {31'b0, miso[0]}, 32'd1);
        rst    = 1'b1;
        cs_pin = 1'b1;
        #1;
        chk("rstmid_miso", {31'b0, miso[0]}, 32'd0);
        chk("rstmid_oe", {31'b0, oe[0]}, 32'd0);
        chk("rstmid_ready", {31'b0, wr_ready[0]}, 32'd1);
        chk("rstmid_read_data", {24'b0, rd_data[0]}, 32'd0);
        chk("rstmid_read_valid", {31'b0, rd_valid[0]}, 32'd0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(4);
        exp_rx.push_back(8'h99);
        exp_tx.push_back(8'h00);
        cs_low();
        spi_word(8'h99, 8);
        cs_high();

        // Write presented in the same cycle as the CS-fall load, buffer empty
        exp_rx.push_back(8'hC3);
        exp_rx.push_back(8'h3C);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h11);
        wait_cyc(1);
        cs_pin = 1'b0;            // pin change after edge k
        wait_cyc(2);              // after edge k+2: fall detected this cycle
        wr_data  = 8'h11;
        wr_valid = 1'b1;
        wait_cyc(1);              // edge k+3: load and write accept together
        wr_valid = 1'b0;
        chk("wdl_ready_after_accept", {31'b0, wr_ready[0]}, 32'd0);
        wait_cyc(H);
        spi_word(8'hC3, 8);
        spi_word(8'h3C, 8);
        cs_high();

        wait_cyc(20);
        chk("exp_rx_drained", exp_rx.size(), 32'd0);
        chk("exp_tx_drained", exp_tx.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
